alu_arbiter: RTL and testbench

//   Shares one alu_top instance between two requesters (port 0, port 1) with

---
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu_top instance between two requesters.
// Grants round-robin, holds the granted operands on the ALU for SETTLE
// cycles, captures the result, and returns it tagged with the requester id.
// The raw ALU overflow is masked to add/sub, and divide-by-zero is trapped.
module alu_arbiter #(
    parameter int width  = 6,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [width-1:0]   req0_a,
    input  logic [width-1:0]   req0_b,
    input  logic [1:0]         req0_func,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [width-1:0]   req1_a,
    input  logic [width-1:0]   req1_b,
    input  logic [1:0]         req1_func,
    output logic [width-1:0]   alu_a,
    output logic [width-1:0]   alu_b,
    output logic [1:0]         alu_func,
    input  logic [2*width-1:0] alu_out,
    input  logic               alu_ovf,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*width-1:0] rsp_data,
    output logic               rsp_ovf
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] FUNC_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last;      // id granted most recently; the other port wins a tie
    logic          grant;     // port selected this cycle (0 or 1)
    logic          accept;    // a request is taken on the coming edge
    logic          div_zero;  // latched op is a divide by zero
    logic [CW-1:0] cnt;

    // Round-robin selection: on a tie the port not served last wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) && !grant && req0_valid;
    assign req1_ready = (state == IDLE) &&  grant && req1_valid;
    assign accept     = req0_ready || req1_ready;
    assign div_zero   = (alu_func == FUNC_DIV) && (alu_b == '0);

    // State register; rst aborts any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge value of its inputs regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for IDLE -> EXEC -> DONE -> IDLE.
    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so
        // no latch is inferred for state_nxt.
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)        state_nxt = EXEC;
            EXEC: if (cnt == '0)     state_nxt = DONE;
            DONE: if (rsp_ready)     state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, settle counter, result capture and release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= 1'b1;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_func  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Operands stay on the ALU between ops to avoid toggling.
                    if (accept) begin
                        alu_a    <= grant ? req1_a    : req0_a;
                        alu_b    <= grant ? req1_b    : req0_b;
                        alu_func <= grant ? req1_func : req0_func;
                        rsp_id   <= grant;
                        last     <= grant;
                        cnt      <= CW'(SETTLE - 1);
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_valid <= 1'b1;
                        if (div_zero) begin
                            rsp_data <= '1;
                            rsp_ovf  <= 1'b1;
                        end else begin
                            rsp_data <= alu_out;
                            rsp_ovf  <= alu_ovf && !alu_func[1];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural alu_top.
module tb_alu_arbiter;

    localparam int W  = 6;
    localparam int ST = 2;

    typedef struct packed {
        logic          id;
        logic [2*W-1:0] data;
        logic          ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [1:0]     req0_func, req1_func;
    logic [W-1:0]   alu_a, alu_b;
    logic [1:0]     alu_func;
    logic [2*W-1:0] alu_out;
    logic           alu_ovf;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_ovf;
    logic [2*W-1:0] rsp_data;
    logic           ovf_force;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    alu_arbiter #(.width(W), .SETTLE(ST)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_out(alu_out), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_ovf(rsp_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural alu_top; divide by zero returns junk the DUT must ignore.
    always_comb begin
        case (alu_func)
            2'b00:   alu_out = 12'(alu_a) + 12'(alu_b);
            2'b01:   alu_out = 12'(alu_a) - 12'(alu_b);
            2'b10:   alu_out = 12'(alu_a) * 12'(alu_b);
            default: alu_out = (alu_b == '0) ? 12'h5A5 : {6'(alu_a / alu_b), 6'(alu_a % alu_b)};
        endcase
    end
    assign alu_ovf = ovf_force;

    function automatic exp_t exp_calc(logic id, logic [W-1:0] a, logic [W-1:0] b,
                                      logic [1:0] f, logic fo);
        exp_t e;
        e.id  = id;
        e.ovf = f[1] ? 1'b0 : fo;
        case (f)
            2'b00: e.data = 12'(a) + 12'(b);
            2'b01: e.data = 12'(a) - 12'(b);
            2'b10: e.data = 12'(a) * 12'(b);
            default: begin
                if (b == '0) begin
                    e.data = 12'hFFF;
                    e.ovf  = 1'b1;
                end else begin
                    e.data = {6'(a / b), 6'(a % b)};
                end
            end
        endcase
        return e;
    endfunction

    task automatic reset_dut();
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        ovf_force = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Present one request, wait for it to be accepted, push its expectation.
    task automatic issue(input logic port, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] f, output bit ok);
        int waited = 0;
        if (port) begin
            req1_a = a; req1_b = b; req1_func = f; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_func = f; req0_valid = 1'b1;
        end
        ok = 1'b0;
        while (waited < 20 && !ok) begin
            @(negedge clk);
            waited++;
            ok = port ? req1_ready : req0_ready;
        end
        if (ok) sb.push_back(exp_calc(port, a, b, f, ovf_force));
        @(posedge clk); #1;
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // Called right after the accepting edge: counts edges until rsp_valid.
    task automatic wait_rsp(output int lat, output exp_t got, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (lat < 50 && !ok) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        got = '{id: rsp_id, data: rsp_data, ovf: rsp_ovf};
        if (ok && rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        ovf_force = 1'b0;
        req0_a = '1; req0_b = '1; req0_func = '1;
        req1_a = '1; req1_b = '1; req1_func = '1;
        @(negedge clk);
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_ovf, rsp_data, alu_a, alu_b, alu_func, req0_ready, req1_ready} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b id=%b ovf=%b data=%h a=%h b=%h func=%b rdy=%b%b, want all 0",
                     rsp_valid, rsp_id, rsp_ovf, rsp_data, alu_a, alu_b, alu_func, req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
    endtask

    // Runs a table of single ops and checks id/data/ovf and latency of each.
    task automatic run_table(input string name, input logic port[], input logic [W-1:0] a[],
                             input logic [W-1:0] b[], input logic [1:0] f[], input logic fo[]);
        bit   ok_i, ok_r;
        int   lat;
        exp_t got, e;
        for (int i = 0; i < a.size(); i++) begin
            ovf_force = fo[i];
            issue(port[i], a[i], b[i], f[i], ok_i);
            if (ok_i) wait_rsp(lat, got, ok_r);
            else begin ok_r = 1'b0; lat = -1; got = '0; end
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            tests_run++;
            if (!ok_i || !ok_r || lat != ST || got !== e) begin
                tests_failed++;
                $display("FAIL %s[%0d]: got ok=%b/%b lat=%0d id=%b data=%h ovf=%b, want lat=%0d id=%b data=%h ovf=%b",
                         name, i, ok_i, ok_r, lat, got.id, got.data, got.ovf, ST, e.id, e.data, e.ovf);
            end
        end
        ovf_force = 1'b0;
    endtask

    task automatic test_add();
        bit   ok_i, ok_r;
        int   lat;
        exp_t got;
        issue(1'b0, 6'd5, 6'd7, 2'b00, ok_i);
        wait_rsp(lat, got, ok_r);
        void'(sb.pop_front());
        tests_run++;
        if (!ok_i || !ok_r || lat != ST || got.data !== 12'd12 || got.id !== 1'b0 || got.ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_5_7: got lat=%0d id=%b data=%0d ovf=%b, want lat=%0d id=0 data=12 ovf=0",
                     lat, got.id, got.data, got.ovf, ST);
        end
    endtask

    task automatic test_round_robin();
        logic exp_id = 1'b0;
        int   got_n = 0;
        int   cyc = 0;
        exp_t e;
        reset_dut();
        req0_a = 6'd3; req0_b = 6'd4; req0_func = 2'b00;
        req1_a = 6'd2; req1_b = 6'd9; req1_func = 2'b10;
        req0_valid = 1'b1; req1_valid = 1'b1;
        while (got_n < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (req0_ready && req1_ready) begin
                tests_run++; tests_failed++;
                $display("FAIL rr_one_ready: got both ready high, want at most one");
            end
            if (req0_ready) sb.push_back(exp_calc(1'b0, req0_a, req0_b, req0_func, 1'b0));
            else if (req1_ready) sb.push_back(exp_calc(1'b1, req1_a, req1_b, req1_func, 1'b0));
            if (rsp_valid) begin
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                tests_run++;
                if (rsp_id !== exp_id || e.id !== exp_id || rsp_data !== e.data || rsp_ovf !== e.ovf) begin
                    tests_failed++;
                    $display("FAIL rr_rsp[%0d]: got id=%b data=%h ovf=%b, want id=%b data=%h ovf=%b",
                             got_n, rsp_id, rsp_data, rsp_ovf, exp_id, e.data, e.ovf);
                end
                exp_id = ~exp_id;
                got_n++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tests_run++;
        if (got_n != 6) begin
            tests_failed++;
            $display("FAIL rr_timeout: got %0d responses, want 6", got_n);
        end
        @(posedge clk); #1;
        sb.delete();
    endtask

    task automatic test_ovf_mask();
        run_table("ovf_mask", '{1'b1, 1'b0, 1'b1, 1'b0},
                  '{6'd63, 6'd0, 6'd7, 6'd40}, '{6'd63, 6'd1, 6'd9, 6'd30},
                  '{2'b10, 2'b01, 2'b10, 2'b00}, '{1'b0, 1'b1, 1'b1, 1'b1});
    endtask

    task automatic test_div();
        run_table("div", '{1'b0, 1'b1, 1'b0},
                  '{6'd17, 6'd17, 6'd63}, '{6'd5, 6'd0, 6'd1},
                  '{2'b11, 2'b11, 2'b11}, '{1'b1, 1'b0, 1'b0});
        // Explicit literals for the two called-out cases.
        ovf_force = 1'b0;
        begin
            bit ok_i, ok_r; int lat; exp_t got;
            issue(1'b1, 6'd17, 6'd5, 2'b11, ok_i);
            wait_rsp(lat, got, ok_r);
            void'(sb.pop_front());
            tests_run++;
            if (got.data !== {6'd3, 6'd2} || got.ovf !== 1'b0) begin
                tests_failed++;
                $display("FAIL div_17_5: got data=%h ovf=%b, want data=%h ovf=0", got.data, got.ovf, {6'd3, 6'd2});
            end
            issue(1'b0, 6'd9, 6'd0, 2'b11, ok_i);
            wait_rsp(lat, got, ok_r);
            void'(sb.pop_front());
            tests_run++;
            if (got.data !== 12'hFFF || got.ovf !== 1'b1) begin
                tests_failed++;
                $display("FAIL div_zero: got data=%h ovf=%b, want data=fff ovf=1", got.data, got.ovf);
            end
        end
    endtask

    task automatic test_backpressure();
        bit   ok_i, ok_r;
        int   lat;
        exp_t got, e;
        int   bad = 0;
        reset_dut();
        rsp_ready = 1'b0;
        issue(1'b1, 6'd10, 6'd3, 2'b01, ok_i);
        wait_rsp(lat, got, ok_r);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        tests_run++;
        if (!ok_r || lat != ST || got !== e) begin
            tests_failed++;
            $display("FAIL bp_first: got lat=%0d id=%b data=%h ovf=%b, want lat=%0d id=%b data=%h ovf=%b",
                     lat, got.id, got.data, got.ovf, ST, e.id, e.data, e.ovf);
        end
        req0_a = 6'd4; req0_b = 6'd5; req0_func = 2'b10; req0_valid = 1'b1;
        req1_a = 6'd1; req1_b = 6'd1; req1_func = 2'b00; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id || req0_ready || req1_ready) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: got %0d unstable cycles, want 0", bad);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_valid: got rsp_valid=%b before handshake, want 1", rsp_valid);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_next_grant: got valid=%b ready=%b%b, want valid=0 ready0=1 ready1=0",
                     rsp_valid, req0_ready, req1_ready);
        end
        sb.push_back(exp_calc(1'b0, req0_a, req0_b, req0_func, ovf_force));
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(lat, got, ok_r);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        tests_run++;
        if (!ok_r || lat != ST || got !== e) begin
            tests_failed++;
            $display("FAIL bp_second: got lat=%0d id=%b data=%h ovf=%b, want lat=%0d id=%b data=%h ovf=%b",
                     lat, got.id, got.data, got.ovf, ST, e.id, e.data, e.ovf);
        end
    endtask

    task automatic test_reset_mid();
        bit ok_i;
        int bad = 0;
        reset_dut();
        issue(1'b1, 6'd9, 6'd9, 2'b10, ok_i);
        sb.delete();
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || alu_a !== '0 || alu_b !== '0 || alu_func !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset: got valid=%b a=%h b=%h func=%b, want all 0",
                     rsp_valid, alu_a, alu_b, alu_func);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL mid_reset_lost: got %0d cycles with rsp_valid, want 0", bad);
        end
        req0_a = 6'd20; req0_b = 6'd5; req0_func = 2'b01; req0_valid = 1'b1;
        req1_a = 6'd1;  req1_b = 6'd1; req1_func = 2'b00; req1_valid = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_grant: got ready=%b%b, want ready0=1 ready1=0", req0_ready, req1_ready);
        end
        req1_valid = 1'b0;
        run_table("post_reset", '{1'b0}, '{6'd20}, '{6'd5}, '{2'b01}, '{1'b0});
    endtask

    initial begin
        test_reset();
        test_add();
        test_round_robin();
        test_ovf_mask();
        test_div();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
